// File: rtl/mem_stage.sv
// mem_stage: memory-access stage sitting directly behind the ALU.
//
// Takes the ALU result plus write-back controls and, for loads and stores,
// runs one transaction on a simple req/ack data bus. Stores are lane-aligned
// and replicated across the word. Loaded bytes and halfwords are extracted from
// the returned word and then sign- or zero-extended. Every accepted operation
// leaves exactly one registered write-back record.
//
// Parameters
//   TIMEOUT   max BUS-state cycles to wait for in_dbus_ack before aborting
//   CNT_W     width of the timeout counter (must hold TIMEOUT)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid .. in_mem_re    operation from the ALU stage (held while out_stall)
//   out_stall                upstream must hold its current operation
//   out_dbus_*               registered bus request fields
//   in_dbus_ack/rdata/err    bus response (rdata/err qualified by ack)
//   out_wb_*                 registered write-back record, one pulse per op
//   out_misalign             pulse: misaligned access dropped without bus activity
//   out_bus_err              pulse: bus error or timeout
module mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    input  logic [4:0]  in_rd_id,
    input  logic        in_rd_we,
    input  logic [31:0] in_data,
    input  logic [31:0] in_mem_addr,
    input  logic [3:0]  in_mem_we,
    input  logic [4:0]  in_mem_re,

    output logic        out_stall,

    output logic        out_dbus_req,
    output logic        out_dbus_we,
    output logic [31:0] out_dbus_addr,
    output logic [3:0]  out_dbus_be,
    output logic [31:0] out_dbus_wdata,
    input  logic        in_dbus_ack,
    input  logic [31:0] in_dbus_rdata,
    input  logic        in_dbus_err,

    output logic        out_wb_valid,
    output logic [4:0]  out_wb_rd_id,
    output logic        out_wb_rd_we,
    output logic [31:0] out_wb_data,
    output logic        out_misalign,
    output logic        out_bus_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    // Counter value of the last BUS cycle we are willing to wait through.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    // Per-transaction context needed when the response comes back.
    logic [1:0]        off_q, off_d;
    logic [4:0]        re_q, re_d;
    logic [4:0]        rd_id_q, rd_id_d;
    logic              rd_we_q, rd_we_d;

    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_id_q, wb_rd_id_d;
    logic              wb_rd_we_q, wb_rd_we_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    // Decode of the incoming operation.
    logic              is_store;
    logic              is_load;
    logic              is_mem;
    logic              is_word;
    logic              is_half;
    logic              misaligned;
    logic              start_bus;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;

    // Bus termination.
    logic              term_ack;
    logic              term_timeout;
    logic              terminate;
    logic              failed;

    // Load extraction.
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_val;

    // Classify the incoming op and work out its access size. A store code
    // takes priority over a load code when both are present.
    always_comb begin
        is_store = |in_mem_we;
        is_load  = !is_store && (|in_mem_re);
        is_mem   = is_store || is_load;

        if (is_store) begin
            is_word = in_mem_we[3];
            is_half = !in_mem_we[3] && in_mem_we[1];
        end else begin
            is_word = in_mem_re[2];
            is_half = !in_mem_re[2] && (in_mem_re[1] || in_mem_re[4]);
        end

        misaligned = is_mem &&
                     ((is_word && (in_mem_addr[1:0] != 2'b00)) ||
                      (is_half && in_mem_addr[0]));

        start_bus = in_valid && (state_q == S_IDLE) && is_mem && !misaligned;
    end

    // Byte enables and lane-replicated write data for the bus request.
    always_comb begin
        if (is_store) begin
            req_be = in_mem_we << in_mem_addr[1:0];
        end else if (is_word) begin
            req_be = 4'b1111;
        end else if (is_half) begin
            req_be = 4'b0011 << in_mem_addr[1:0];
        end else begin
            req_be = 4'b0001 << in_mem_addr[1:0];
        end

        if (!is_store) begin
            req_wdata = 32'h0;
        end else if (is_word) begin
            req_wdata = in_data;
        end else if (is_half) begin
            req_wdata = {2{in_data[15:0]}};
        end else begin
            req_wdata = {4{in_data[7:0]}};
        end
    end

    // A transaction ends on ack, or on the last allowed cycle without one.
    // An ack arriving in IDLE never reaches here because of the state qualifier.
    always_comb begin
        term_ack     = (state_q == S_BUS) && in_dbus_ack;
        term_timeout = (state_q == S_BUS) && !in_dbus_ack && (cnt_q == CNT_LAST);
        terminate    = term_ack || term_timeout;
        failed       = term_timeout || (term_ack && in_dbus_err);
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_v = in_dbus_rdata[{off_q, 3'b000} +: 8];
        half_v = in_dbus_rdata[{off_q[1], 4'b0000} +: 16];

        if (re_q[2]) begin
            load_val = in_dbus_rdata;
        end else if (re_q[1]) begin
            load_val = {{16{half_v[15]}}, half_v};
        end else if (re_q[4]) begin
            load_val = {16'h0, half_v};
        end else if (re_q[0]) begin
            load_val = {{24{byte_v[7]}}, byte_v};
        end else begin
            load_val = {24'h0, byte_v};
        end
    end

    // State register plus every registered output and transaction context.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            off_q      <= 2'b00;
            re_q       <= 5'h0;
            rd_id_q    <= 5'h0;
            rd_we_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_id_q <= 5'h0;
            wb_rd_we_q <= 1'b0;
            wb_data_q  <= 32'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            off_q      <= off_d;
            re_q       <= re_d;
            rd_id_q    <= rd_id_d;
            rd_we_q    <= rd_we_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_id_q <= wb_rd_id_d;
            wb_rd_we_q <= wb_rd_we_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Next state and timeout counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_bus) begin
                    state_d = S_BUS;
                    cnt_d   = '0;
                end
            end
            S_BUS: begin
                if (terminate) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Datapath: bus request capture and the write-back record. Bus fields
    // hold their value for the whole transaction; wb/status pulses default low.
    always_comb begin
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        off_d      = off_q;
        re_d       = re_q;
        rd_id_d    = rd_id_q;
        rd_we_d    = rd_we_q;
        wb_valid_d = 1'b0;
        wb_rd_id_d = wb_rd_id_q;
        wb_rd_we_d = wb_rd_we_q;
        wb_data_d  = wb_data_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        if (state_q == S_IDLE && in_valid) begin
            if (!is_mem) begin
                wb_valid_d = 1'b1;
                wb_rd_id_d = in_rd_id;
                wb_rd_we_d = in_rd_we;
                wb_data_d  = in_data;
            end else if (misaligned) begin
                wb_valid_d = 1'b1;
                wb_rd_id_d = in_rd_id;
                wb_rd_we_d = 1'b0;
                wb_data_d  = 32'h0;
                misalign_d = 1'b1;
            end else begin
                req_d   = 1'b1;
                we_d    = is_store;
                addr_d  = {in_mem_addr[31:2], 2'b00};
                be_d    = req_be;
                wdata_d = req_wdata;
                off_d   = in_mem_addr[1:0];
                re_d    = in_mem_re;
                rd_id_d = in_rd_id;
                // A store never writes the register file.
                rd_we_d = in_rd_we && !is_store;
            end
        end else if (terminate) begin
            req_d      = 1'b0;
            wb_valid_d = 1'b1;
            wb_rd_id_d = rd_id_q;
            if (failed) begin
                wb_rd_we_d = 1'b0;
                wb_data_d  = 32'h0;
                bus_err_d  = 1'b1;
            end else begin
                wb_rd_we_d = rd_we_q;
                wb_data_d  = we_q ? 32'h0 : load_val;
            end
        end
    end

    // Stall: in IDLE while an aligned memory op is being launched, and in
    // BUS on every cycle except the terminating one so upstream can advance.
    always_comb begin
        if (state_q == S_IDLE) begin
            out_stall = start_bus;
        end else begin
            out_stall = !terminate;
        end
    end

    assign out_dbus_req   = req_q;
    assign out_dbus_we    = we_q;
    assign out_dbus_addr  = addr_q;
    assign out_dbus_be    = be_q;
    assign out_dbus_wdata = wdata_q;
    assign out_wb_valid   = wb_valid_q;
    assign out_wb_rd_id   = wb_rd_id_q;
    assign out_wb_rd_we   = wb_rd_we_q;
    assign out_wb_data    = wb_data_q;
    assign out_misalign   = misalign_q;
    assign out_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: testbench for mem_stage.
// The driver presents one operation at a time and acts as the bus slave.
// It works out from the operation what every cycle of the transaction should
// look like and writes that into a per-cycle expectation table. A compare
// process walks the table on each falling edge. Directed cases also check a
// few hand-computed literal values that pin the table itself.
module tb_mem_stage;

    localparam int TO     = 4;
    localparam int NSCHED = 8192;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_rd_id;
    logic        in_rd_we;
    logic [31:0] in_data;
    logic [31:0] in_mem_addr;
    logic [3:0]  in_mem_we;
    logic [4:0]  in_mem_re;
    logic        out_stall;
    logic        out_dbus_req;
    logic        out_dbus_we;
    logic [31:0] out_dbus_addr;
    logic [3:0]  out_dbus_be;
    logic [31:0] out_dbus_wdata;
    logic        in_dbus_ack;
    logic [31:0] in_dbus_rdata;
    logic        in_dbus_err;
    logic        out_wb_valid;
    logic [4:0]  out_wb_rd_id;
    logic        out_wb_rd_we;
    logic [31:0] out_wb_data;
    logic        out_misalign;
    logic        out_bus_err;

    mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rd_id(in_rd_id), .in_rd_we(in_rd_we),
        .in_data(in_data), .in_mem_addr(in_mem_addr),
        .in_mem_we(in_mem_we), .in_mem_re(in_mem_re),
        .out_stall(out_stall),
        .out_dbus_req(out_dbus_req), .out_dbus_we(out_dbus_we),
        .out_dbus_addr(out_dbus_addr), .out_dbus_be(out_dbus_be),
        .out_dbus_wdata(out_dbus_wdata),
        .in_dbus_ack(in_dbus_ack), .in_dbus_rdata(in_dbus_rdata),
        .in_dbus_err(in_dbus_err),
        .out_wb_valid(out_wb_valid), .out_wb_rd_id(out_wb_rd_id),
        .out_wb_rd_we(out_wb_rd_we), .out_wb_data(out_wb_data),
        .out_misalign(out_misalign), .out_bus_err(out_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // What the outputs must look like during one cycle.
    typedef struct {
        bit          stall;
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          chk_wdata;
        logic [31:0] wdata;
        bit          wb_valid;
        logic [4:0]  rd_id;
        bit          rd_we;
        bit          chk_data;
        logic [31:0] data;
        bit          misalign;
        bit          bus_err;
    } exp_t;

    exp_t sched [NSCHED];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, want);
        end
    endtask

    // Per-cycle comparison against the expectation table.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (cyc >= 1 && cyc < NSCHED) begin
            e = sched[cyc];
            checkOutput("stall",    32'(out_stall),    32'(e.stall));
            checkOutput("req",      32'(out_dbus_req), 32'(e.req));
            checkOutput("wb_valid", 32'(out_wb_valid), 32'(e.wb_valid));
            checkOutput("misalign", 32'(out_misalign), 32'(e.misalign));
            checkOutput("bus_err",  32'(out_bus_err),  32'(e.bus_err));
            if (e.req) begin
                checkOutput("bus_we",   32'(out_dbus_we), 32'(e.we));
                checkOutput("bus_addr", out_dbus_addr,    e.addr);
                checkOutput("bus_be",   32'(out_dbus_be), 32'(e.be));
                if (e.chk_wdata) checkOutput("bus_wdata", out_dbus_wdata, e.wdata);
            end
            if (e.wb_valid) begin
                checkOutput("wb_rd_id", 32'(out_wb_rd_id), 32'(e.rd_id));
                checkOutput("wb_rd_we", 32'(out_wb_rd_we), 32'(e.rd_we));
                if (e.chk_data) checkOutput("wb_data", out_wb_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle with no operation; garbage on every other input, including acks.
    task automatic idleCycle();
        in_valid      = 1'b0;
        in_rd_id      = 5'($urandom);
        in_rd_we      = 1'($urandom);
        in_data       = $urandom;
        in_mem_addr   = $urandom;
        in_mem_we     = 4'($urandom);
        in_mem_re     = 5'($urandom);
        in_dbus_ack   = 1'($urandom);
        in_dbus_rdata = $urandom;
        in_dbus_err   = 1'($urandom);
        step();
    endtask

    // Present one op, play the bus slave (ack after wait_n wait cycles, or never
    // if that exceeds the timeout) and record the expected cycle-by-cycle view.
    // Returns at the cycle after termination, where the write-back is visible.
    task automatic applyStimulus(
        input  logic [4:0]  rd_id,
        input  logic        rd_we,
        input  logic [31:0] data,
        input  logic [31:0] addr,
        input  logic [3:0]  mwe,
        input  logic [4:0]  mre,
        input  int          wait_n,
        input  logic        err,
        input  logic [31:0] rdata,
        output int          stall_n,
        output int          req_n,
        output int          lat,
        output logic [31:0] b_addr,
        output logic [3:0]  b_be,
        output logic        b_we,
        output logic [31:0] b_wdata
    );
        int c, size, k, n, m;
        bit store, load, mis, tmo, bad;
        logic [31:0] wd, ld, part;
        c = cyc;
        stall_n = 0; req_n = 0;
        b_addr = 32'h0; b_be = 4'h0; b_we = 1'b0; b_wdata = 32'h0;

        in_valid      = 1'b1;
        in_rd_id      = rd_id;
        in_rd_we      = rd_we;
        in_data       = data;
        in_mem_addr   = addr;
        in_mem_we     = mwe;
        in_mem_re     = mre;
        in_dbus_ack   = 1'($urandom);
        in_dbus_rdata = $urandom;
        in_dbus_err   = 1'($urandom);

        store = (mwe != 4'h0);
        load  = !store && (mre != 5'h0);
        if (store) size = (mwe == 4'b1111) ? 4 : (mwe == 4'b0011) ? 2 : 1;
        else       size = mre[2] ? 4 : (mre[1] || mre[4]) ? 2 : 1;
        k   = int'(addr[1:0]);
        mis = (store || load) && ((k % size) != 0);

        if (!(store || load) || mis) begin
            sched[c+1].wb_valid = 1'b1;
            sched[c+1].rd_id    = rd_id;
            sched[c+1].rd_we    = mis ? 1'b0 : rd_we;
            sched[c+1].chk_data = !mis;
            sched[c+1].data     = data;
            sched[c+1].misalign = mis;
            #1;
            if (out_stall) stall_n++;
            if (out_dbus_req) req_n++;
            step();
            lat = cyc - c;
            return;
        end

        tmo = (wait_n + 1) > TO;
        n   = tmo ? TO : wait_n + 1;
        m   = ((1 << size) - 1) << k;
        if (size == 4)      wd = data;
        else if (size == 2) wd = (data & 32'h0000_FFFF) * 32'h0001_0001;
        else                wd = (data & 32'h0000_00FF) * 32'h0101_0101;

        for (int i = 0; i < n; i++) sched[c+i].stall = 1'b1;
        for (int i = 1; i <= n; i++) begin
            sched[c+i].req       = 1'b1;
            sched[c+i].we        = store;
            sched[c+i].addr      = addr & 32'hFFFF_FFFC;
            sched[c+i].be        = 4'(m);
            sched[c+i].chk_wdata = store;
            sched[c+i].wdata     = wd;
        end

        #1;
        if (out_stall) stall_n++;
        if (out_dbus_req) req_n++;
        step();

        for (int i = 0; i < n; i++) begin
            in_dbus_ack   = !tmo && (i == wait_n);
            in_dbus_rdata = (i == wait_n) ? rdata : $urandom;
            in_dbus_err   = (i == wait_n) ? err : 1'($urandom);
            #1;
            if (out_stall) stall_n++;
            if (out_dbus_req) req_n++;
            if (i == 0) begin
                b_addr = out_dbus_addr; b_be = out_dbus_be;
                b_we = out_dbus_we; b_wdata = out_dbus_wdata;
            end
            step();
        end

        bad = tmo || err;
        ld  = 32'h0;
        if (load && !bad) begin
            if (size == 4) begin
                ld = rdata;
            end else if (size == 2) begin
                part = (rdata >> (16 * (k / 2))) & 32'h0000_FFFF;
                ld = (mre[1] && part >= 32'h8000) ? part - 32'h0001_0000 : part;
            end else begin
                part = (rdata >> (8 * k)) & 32'h0000_00FF;
                ld = (mre[0] && part >= 32'h80) ? part - 32'h0000_0100 : part;
            end
        end
        sched[c+n+1].wb_valid = 1'b1;
        sched[c+n+1].rd_id    = rd_id;
        sched[c+n+1].rd_we    = (bad || store) ? 1'b0 : rd_we;
        sched[c+n+1].chk_data = load && !bad;
        sched[c+n+1].data     = ld;
        sched[c+n+1].bus_err  = bad;
        lat = cyc - c;
    endtask

    int          st_n, rq_n, lt;
    logic [31:0] ba, bw;
    logic [3:0]  bb;
    logic        bwe;

    initial begin
        int c0, kind;
        logic [3:0]  mwe;
        logic [4:0]  mre;
        logic [3:0]  codes [3];
        codes[0] = 4'b0001; codes[1] = 4'b0011; codes[2] = 4'b1111;

        rst = 1'b1; in_valid = 1'b0; in_rd_id = 5'h0; in_rd_we = 1'b0;
        in_data = 32'h0; in_mem_addr = 32'h0; in_mem_we = 4'h0; in_mem_re = 5'h0;
        in_dbus_ack = 1'b0; in_dbus_rdata = 32'h0; in_dbus_err = 1'b0;

        step();
        checkOutput("rst_req",    32'(out_dbus_req),   32'h0);
        checkOutput("rst_addr",   out_dbus_addr,       32'h0);
        checkOutput("rst_be",     32'(out_dbus_be),    32'h0);
        checkOutput("rst_wdata",  out_dbus_wdata,      32'h0);
        checkOutput("rst_wb_data", out_wb_data,        32'h0);
        checkOutput("rst_wb_valid", 32'(out_wb_valid), 32'h0);
        step();
        rst = 1'b0;

        // Non-memory op.
        applyStimulus(5'd5, 1'b1, 32'h1234_5678, 32'h0, 4'h0, 5'h0, 0, 1'b0, 32'h0,
                      st_n, rq_n, lt, ba, bb, bwe, bw);
        checkOutput("nm_wb_data",  out_wb_data,         32'h1234_5678);
        checkOutput("nm_wb_rd_id", 32'(out_wb_rd_id),   32'd5);
        checkOutput("nm_wb_rd_we", 32'(out_wb_rd_we),   32'd1);
        checkOutput("nm_stall_n",  32'(st_n),           32'd0);
        checkOutput("nm_latency",  32'(lt),             32'd1);

        // LB at 0x1003, three wait cycles.
        applyStimulus(5'd9, 1'b1, 32'h0, 32'h0000_1003, 4'h0, 5'b00001, 3, 1'b0, 32'h80AA_BBCC,
                      st_n, rq_n, lt, ba, bb, bwe, bw);
        checkOutput("lb_addr",    ba,             32'h0000_1000);
        checkOutput("lb_be",      32'(bb),        32'h8);
        checkOutput("lb_stall_n", 32'(st_n),      32'd4);
        checkOutput("lb_wb_data", out_wb_data,    32'hFFFF_FF80);

        // Same as LBU.
        applyStimulus(5'd9, 1'b1, 32'h0, 32'h0000_1003, 4'h0, 5'b01000, 3, 1'b0, 32'h80AA_BBCC,
                      st_n, rq_n, lt, ba, bb, bwe, bw);
        checkOutput("lbu_wb_data", out_wb_data,   32'h0000_0080);

        // SH at 0x2002, ack in first BUS cycle.
        applyStimulus(5'd3, 1'b1, 32'hDEAD_BEEF, 32'h0000_2002, 4'b0011, 5'h0, 0, 1'b0, 32'h0,
                      st_n, rq_n, lt, ba, bb, bwe, bw);
        checkOutput("sh_be",      32'(bb),          32'hC);
        checkOutput("sh_wdata",   bw,               32'hBEEF_BEEF);
        checkOutput("sh_we",      32'(bwe),         32'd1);
        checkOutput("sh_latency", 32'(lt),          32'd2);
        checkOutput("sh_wb_rd_we", 32'(out_wb_rd_we), 32'd0);

        // Misaligned LW.
        applyStimulus(5'd4, 1'b1, 32'h0, 32'h0000_0006, 4'h0, 5'b00100, 0, 1'b0, 32'h0,
                      st_n, rq_n, lt, ba, bb, bwe, bw);
        checkOutput("mis_req_n",    32'(rq_n),          32'd0);
        checkOutput("mis_stall_n",  32'(st_n),          32'd0);
        checkOutput("mis_flag",     32'(out_misalign),  32'd1);
        checkOutput("mis_wb_rd_we", 32'(out_wb_rd_we),  32'd0);

        // Timeout: never ack.
        applyStimulus(5'd6, 1'b1, 32'h0, 32'h0000_0040, 4'h0, 5'b00100, 99, 1'b0, 32'h0,
                      st_n, rq_n, lt, ba, bb, bwe, bw);
        checkOutput("to_req_n",    32'(rq_n),          32'd4);
        checkOutput("to_bus_err",  32'(out_bus_err),   32'd1);
        checkOutput("to_wb_rd_we", 32'(out_wb_rd_we),  32'd0);
        applyStimulus(5'd7, 1'b1, 32'hCAFE_0001, 32'h0, 4'h0, 5'h0, 0, 1'b0, 32'h0,
                      st_n, rq_n, lt, ba, bb, bwe, bw);
        checkOutput("to_next_wb_data", out_wb_data, 32'hCAFE_0001);

        // Reset in the second BUS cycle abandons the transaction.
        c0 = cyc;
        in_valid = 1'b1; in_rd_id = 5'd7; in_rd_we = 1'b1; in_data = 32'h0;
        in_mem_addr = 32'h0000_0100; in_mem_we = 4'h0; in_mem_re = 5'b00100;
        in_dbus_ack = 1'b0;
        for (int i = 0; i < 3; i++) sched[c0+i].stall = 1'b1;
        for (int i = 1; i < 3; i++) begin
            sched[c0+i].req  = 1'b1;
            sched[c0+i].we   = 1'b0;
            sched[c0+i].addr = 32'h0000_0100;
            sched[c0+i].be   = 4'hF;
        end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checkOutput("rst_bus_req",      32'(out_dbus_req), 32'd0);
        checkOutput("rst_bus_wb_valid", 32'(out_wb_valid), 32'd0);
        step();
        applyStimulus(5'd2, 1'b1, 32'h0BAD_F00D, 32'h0, 4'h0, 5'h0, 0, 1'b0, 32'h0,
                      st_n, rq_n, lt, ba, bb, bwe, bw);
        checkOutput("post_rst_wb_data", out_wb_data, 32'h0BAD_F00D);

        // Random mix of operations, bus latencies, errors and idle gaps.
        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 9);
            mwe  = 4'h0;
            mre  = 5'h0;
            if (kind >= 2 && kind <= 4) mwe = codes[$urandom_range(0, 2)];
            if (kind >= 5) mre = 5'(1 << $urandom_range(0, 4));
            if (kind == 9) mwe = codes[$urandom_range(0, 2)];
            applyStimulus(5'($urandom), 1'($urandom), $urandom, $urandom, mwe, mre,
                          $urandom_range(0, 5), ($urandom_range(0, 7) == 0), $urandom,
                          st_n, rq_n, lt, ba, bb, bwe, bw);
            if ($urandom_range(0, 3) == 0) idleCycle();
        end

        repeat (4) idleCycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
